// File: rtl/shape_processor_arbiter.sv
// -----------------------------------------------------------------------------
// shape_processor_arbiter
//
// Shares a single shape_processor between NUM_REQ requesters. A granted
// request's SHAPE/OPERATION pair is written into the processor's CTRL SFR,
// the processor's error flag is sampled on the following cycle, and after a
// fixed wait the result is read back and returned to the requester.
// Round-robin grant with a single outstanding transaction.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   WAIT_CYCLES  idle cycles between the CTRL write and the result read (1..15)
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept (combinational, one-hot or zero)
//   req_shape      2-bit SHAPE field per requester (slice i = requester i)
//   req_operation  5-bit OPERATION field per requester (slice i = requester i)
//   resp_valid     one-cycle response pulse to the granted requester
//   resp_data      result, valid with resp_valid
//   resp_error     error flag, valid with resp_valid
//   write          CTRL SFR write strobe to shape_processor
//   write_data     CTRL word: [17:16]=SHAPE, [4:0]=OPERATION, rest 0
//   read           result read strobe to shape_processor
//   read_data      result from shape_processor (valid the cycle after read)
//   error          processor error flag (valid the cycle after write)
//
// Optional feature (compile-time macro):
//   SHAPE_PROCESSOR_ARBITER_LEGALITY_CHECK_EN
//     When defined, illegal SHAPE/OPERATION combinations are rejected in IDLE
//     and answered with resp_error=1 one cycle after accept, without touching
//     the processor. When undefined, every request is forwarded and
//     illegality is reported only through the processor's error flag.
// -----------------------------------------------------------------------------
module shape_processor_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_shape,
    input  logic [5*NUM_REQ-1:0]   req_operation,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    output logic                   resp_error,
    output logic                   write,
    output logic [31:0]            write_data,
    output logic                   read,
    input  logic [31:0]            read_data,
    input  logic                   error
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ERRCHK,
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [1:0]         shape_reg;
    logic [4:0]         op_reg;
    logic [3:0]         cnt_reg;
    logic [31:0]        resp_data_reg;
    logic               resp_error_reg;

    logic               any_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [1:0]         sel_shape;
    logic [4:0]         sel_op;
    logic               accept_illegal;

    logic [1:0]         shape_arr [NUM_REQ];
    logic [4:0]         op_arr    [NUM_REQ];

    // Split the packed request buses into per-requester fields and build the
    // one-hot ready/response vectors.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign shape_arr[gi]  = req_shape[2*gi +: 2];
            assign op_arr[gi]     = req_operation[5*gi +: 5];
            // rst_n gating keeps ready low while reset is held, even though
            // the FSM already sits in IDLE.
            assign req_ready[gi]  = rst_n && (state_reg == ST_IDLE) && any_valid
                                    && (grant_idx == IDX_W'(gi));
            assign resp_valid[gi] = (state_reg == ST_RESP) && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Round-robin search: scan from farthest to nearest position after the
    // pointer so the nearest valid requester is the last one assigned.
    always_comb begin
        any_valid = |req_valid;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_reg) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_idx = cand;
            end
        end
    end

    assign sel_shape = shape_arr[grant_idx];
    assign sel_op    = op_arr[grant_idx];

`ifdef SHAPE_PROCESSOR_ARBITER_LEGALITY_CHECK_EN
    function automatic logic legal_req(input logic [1:0] s, input logic [4:0] o);
        logic is_rect;
        logic is_tri;
        is_rect = (s == 2'b01);
        is_tri  = (s == 2'b10);
        case (o)
            5'b00000, 5'b00001: return is_rect || is_tri;  // PERIMETER, AREA
            5'b01000:           return is_rect;            // IS_SQUARE
            5'b10000, 5'b10001: return is_tri;             // IS_EQUILATERAL/ISOSCELES
            default:            return 1'b0;
        endcase
    endfunction

    assign accept_illegal = !legal_req(sel_shape, sel_op);
`else
    assign accept_illegal = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (any_valid) state_next = accept_illegal ? ST_RESP : ST_WRITE;
            ST_WRITE:   state_next = ST_ERRCHK;
            ST_ERRCHK:  state_next = error ? ST_RESP : ST_WAIT;
            ST_WAIT:    if (cnt_reg == 4'd1) state_next = ST_READ;
            ST_READ:    state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        write      = (state_reg == ST_WRITE);
        read       = (state_reg == ST_READ);
        write_data = write ? {14'd0, shape_reg, 11'd0, op_reg} : 32'd0;
        resp_data  = resp_data_reg;
        resp_error = resp_error_reg;
    end

    // Datapath: latched request fields, wait counter and response registers.
    // resp_data is only meaningful with resp_valid, so it is left holding its
    // last value between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg         <= IDX_W'(NUM_REQ - 1);
            grant_reg      <= '0;
            shape_reg      <= '0;
            op_reg         <= '0;
            cnt_reg        <= '0;
            resp_data_reg  <= '0;
            resp_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_reg      <= grant_idx;
                        rr_reg         <= grant_idx;
                        shape_reg      <= sel_shape;
                        op_reg         <= sel_op;
                        resp_error_reg <= accept_illegal;
                        if (accept_illegal) begin
                            resp_data_reg <= '0;
                        end
                    end
                end
                ST_ERRCHK: begin
                    if (error) begin
                        resp_error_reg <= 1'b1;
                        resp_data_reg  <= '0;
                    end else begin
                        cnt_reg <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
                ST_CAPTURE: begin
                    resp_data_reg <= read_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_processor_arbiter.sv
module tb_shape_processor_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_shape;
    logic [9:0]  req_operation;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        error;

    int total = 0;
    int bad   = 0;

    // Observations collected over one transaction (cycle 0 = accept cycle)
    int          w_cyc, r_cyc, v_cyc;
    logic [31:0] w_data, v_data;
    logic [1:0]  v_bits;
    logic        v_err;
    bit          overlap, ready_busy;

    always #5 clk = ~clk;

    shape_processor_arbiter #(
        .NUM_REQ     (2),
        .WAIT_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_shape     (req_shape),
        .req_operation (req_operation),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .write         (write),
        .write_data    (write_data),
        .read          (read),
        .read_data     (read_data),
        .error         (error)
    );

    // Follows one transaction from the accept cycle until the response pulse
    // (or the cycle budget runs out). Inputs are changed after the accept edge.
    task automatic observe(input int max_cyc, input logic [1:0] valid_after,
                           input logic [3:0] shape_after);
        w_cyc = -1; r_cyc = -1; v_cyc = -1;
        w_data = '0; v_data = '0; v_bits = '0; v_err = 1'b0;
        overlap = 1'b0; ready_busy = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = valid_after;
                req_shape = shape_after;
            end
            #1;
            if (write && read) overlap = 1'b1;
            if (write && w_cyc < 0) begin w_cyc = i; w_data = write_data; end
            if (read && r_cyc < 0) r_cyc = i;
            if (req_ready != 2'b00) ready_busy = 1'b1;
            if (resp_valid != 2'b00) begin
                v_cyc = i; v_bits = resp_valid; v_data = resp_data; v_err = resp_error;
                break;
            end
        end
        $display("txn: resp_valid=%b at cycle %0d data=%h err=%b write@%0d read@%0d",
                 v_bits, v_cyc, v_data, v_err, w_cyc, r_cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_shape = 4'b1001;
        req_operation = 10'b00001_00000;
        read_data = 32'h0;
        error = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
        total++; if (write !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", write, read); end
        total++; if (write_data !== 32'h0) begin bad++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
        total++; if (resp_data !== 32'h0 || resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp got=%h/%b exp=0/0", resp_data, resp_error); end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        req_shape = 4'b0001;            // req0 RECTANGLE
        req_operation = 10'b00000_00001; // req0 AREA
        read_data = 32'hCAFE_1234;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL basic_ready got=%b exp=01", req_ready); end
        observe(20, 2'b00, req_shape);
        total++; if (w_cyc !== 1) begin bad++; $display("FAIL basic_write_cycle got=%0d exp=1", w_cyc); end
        total++; if (w_data !== 32'h0001_0001) begin bad++; $display("FAIL basic_write_data got=%h exp=00010001", w_data); end
        total++; if (r_cyc !== 5) begin bad++; $display("FAIL basic_read_cycle got=%0d exp=5", r_cyc); end
        total++; if (v_cyc !== 7) begin bad++; $display("FAIL basic_resp_cycle got=%0d exp=7", v_cyc); end
        total++; if (v_bits !== 2'b01) begin bad++; $display("FAIL basic_resp_valid got=%b exp=01", v_bits); end
        total++; if (v_data !== 32'hCAFE_1234) begin bad++; $display("FAIL basic_resp_data got=%h exp=cafe1234", v_data); end
        total++; if (v_err !== 1'b0) begin bad++; $display("FAIL basic_resp_error got=%b exp=0", v_err); end
        total++; if (overlap !== 1'b0) begin bad++; $display("FAIL basic_write_read_overlap got=%b exp=0", overlap); end
        @(negedge clk); #1;
        total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL basic_resp_pulse_width got=%b exp=00", resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        int waited;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_shape = 4'b1001;               // req0 RECTANGLE, req1 TRIANGLE
        req_operation = 10'b00001_00000;   // req0 PERIMETER, req1 AREA
        req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            while (req_ready == 2'b00 && waited < 20) begin
                @(negedge clk); #1;
                waited++;
            end
            read_data = 32'h1000_0000 + 32'(t);
            total++; if (req_ready !== exp_g[t]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", t, req_ready, exp_g[t]); end
            if (t > 0) begin
                total++; if (waited !== 1) begin bad++; $display("FAIL rr_gap%0d got=%0d exp=1", t, waited); end
            end
            observe(20, 2'b11, req_shape);
            total++; if (v_bits !== exp_g[t]) begin bad++; $display("FAIL rr_resp%0d got=%b exp=%b", t, v_bits, exp_g[t]); end
            total++; if (v_data !== 32'h1000_0000 + 32'(t)) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", t, v_data, 32'h1000_0000 + 32'(t)); end
            total++; if (ready_busy !== 1'b0) begin bad++; $display("FAIL rr_ready_busy%0d got=%b exp=0", t, ready_busy); end
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        req_valid = 2'b01;
        read_data = 32'h5555_AAAA;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_ready got=%b exp=01", req_ready); end
        repeat (3) @(negedge clk);     // WRITE, ERRCHK, first WAIT cycle
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin bad++; $display("FAIL midrst_handshake got=%b/%b exp=00/00", req_ready, resp_valid); end
        total++; if (write !== 1'b0 || read !== 1'b0 || write_data !== 32'h0) begin bad++; $display("FAIL midrst_proc_port got=%b%b/%h exp=00/0", write, read, write_data); end
        total++; if (resp_data !== 32'h0 || resp_error !== 1'b0) begin bad++; $display("FAIL midrst_resp got=%h/%b exp=0/0", resp_data, resp_error); end
        @(negedge clk);
        req_valid = 2'b10;
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL midrst_regrant got=%b exp=10", req_ready); end
        observe(20, 2'b00, req_shape);
        total++; if (v_bits !== 2'b10 || v_cyc !== 7) begin bad++; $display("FAIL midrst_resp_after got=%b@%0d exp=10@7", v_bits, v_cyc); end
        total++; if (v_data !== 32'h5555_AAAA) begin bad++; $display("FAIL midrst_data got=%h exp=5555aaaa", v_data); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_shape = 4'b0101;               // req1 RECTANGLE
        req_operation = 10'b10000_00000;   // req1 IS_EQUILATERAL
        read_data = 32'h7777_7777;
        error = 1'b1;
        req_valid = 2'b10;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL illegal_ready got=%b exp=10", req_ready); end
        observe(20, 2'b00, req_shape);
        total++; if (v_bits !== 2'b10) begin bad++; $display("FAIL illegal_resp_valid got=%b exp=10", v_bits); end
        total++; if (v_err !== 1'b1) begin bad++; $display("FAIL illegal_resp_error got=%b exp=1", v_err); end
        total++; if (v_data !== 32'h0) begin bad++; $display("FAIL illegal_resp_data got=%h exp=0", v_data); end
        total++; if (r_cyc !== -1) begin bad++; $display("FAIL illegal_read got=%0d exp=-1", r_cyc); end
`ifdef SHAPE_PROCESSOR_ARBITER_LEGALITY_CHECK_EN
        total++; if (v_cyc !== 1) begin bad++; $display("FAIL illegal_latency got=%0d exp=1", v_cyc); end
        total++; if (w_cyc !== -1) begin bad++; $display("FAIL illegal_write got=%0d exp=-1", w_cyc); end
`else
        total++; if (v_cyc !== 3) begin bad++; $display("FAIL illegal_latency got=%0d exp=3", v_cyc); end
        total++; if (w_cyc !== 1 || w_data !== 32'h0001_0010) begin bad++; $display("FAIL illegal_write got=%0d/%h exp=1/00010010", w_cyc, w_data); end
`endif
        error = 1'b0;
    endtask

    task automatic test_latched_fields();
        @(negedge clk);
        req_shape = 4'b0010;               // req0 TRIANGLE
        req_operation = 10'b00000_10001;   // req0 IS_ISOSCELES
        read_data = 32'h0000_0ABC;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL latch_ready got=%b exp=01", req_ready); end
        observe(20, 2'b00, 4'b0001);       // shape changes to RECTANGLE after accept
        total++; if (w_data !== 32'h0002_0011) begin bad++; $display("FAIL latch_write_data got=%h exp=00020011", w_data); end
        total++; if (v_cyc !== 7 || v_bits !== 2'b01) begin bad++; $display("FAIL latch_resp got=%b@%0d exp=01@7", v_bits, v_cyc); end
        total++; if (v_data !== 32'h0000_0ABC || v_err !== 1'b0) begin bad++; $display("FAIL latch_data got=%h/%b exp=00000abc/0", v_data, v_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_reset_mid_wait();
        test_illegal();
        test_latched_fields();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shape_processor_arbiter.md
Name: shape_processor_arbiter

Overview:
- Shares one shape_processor between NUM_REQ requesters.
- Each request carries a SHAPE/OPERATION pair. The arbiter programs the CTRL SFR through the processor's write port, waits a fixed latency, reads the result through the read port, and returns it to the winning requester.
- Round-robin grant; only one transaction is outstanding at a time.
- Sits between client blocks and shape_processor; it is the only driver of the processor's write/read inputs.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- WAIT_CYCLES, 2: idle cycles between the CTRL write and the result read, 1..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_shape  input  2*NUM_REQ  SHAPE field; slice i belongs to requester i.
- req_operation  input  5*NUM_REQ  OPERATION field; slice i belongs to requester i.
- resp_valid  output  NUM_REQ  one-cycle response pulse, one-hot or zero.
- resp_data  output  32  result; valid while any resp_valid bit is high.
- resp_error  output  1  error flag; valid with resp_valid.
- write  output  1  CTRL SFR write strobe to shape_processor.
- write_data  output  32  CTRL word: bits[17:16]=SHAPE, bits[4:0]=OPERATION, all other bits 0.
- read  output  1  result read strobe to shape_processor.
- read_data  input  32  result from shape_processor, sampled one cycle after read.
- error  input  1  processor error flag, sampled one cycle after write.

Behaviour:
- Reset is asynchronous on rst_n low:
  - FSM goes to IDLE, rr pointer to NUM_REQ-1 (requester 0 wins first), wait counter to 0.
  - req_ready, resp_valid, resp_error, write, read, write_data and resp_data all go to 0.
- Encodings:
  - SHAPE: RECTANGLE=2'b01, TRIANGLE=2'b10.
  - OPERATION: PERIMETER=5'b00000, AREA=5'b00001, IS_SQUARE=5'b01000, IS_EQUILATERAL=5'b10000, IS_ISOSCELES=5'b10001.
- Legal combinations:
  - PERIMETER and AREA with either shape.
  - IS_SQUARE with RECTANGLE only.
  - IS_EQUILATERAL and IS_ISOSCELES with TRIANGLE only.
- FSM states: IDLE, WRITE, ERRCHK, WAIT, READ, CAPTURE, RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit strictly after the rr pointer, wrapping around.
  - Drive req_ready[g]=1 combinationally for that cycle. The handshake is req_valid & req_ready.
  - Latch g, shape and operation; update the rr pointer to g.
  - Next state is WRITE, or RESP with error when the legality check rejects (see Optional Feature).
- WRITE: write=1 with write_data built from the latched fields, for exactly one cycle; go to ERRCHK.
- ERRCHK: sample error. If 1, go to RESP with resp_error=1 and resp_data=0. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT: decrement the counter; go to READ when it reaches 0. There are exactly WAIT_CYCLES cycles between ERRCHK and READ.
- READ: read=1 for one cycle; go to CAPTURE.
- CAPTURE: register read_data into resp_data; go to RESP.
- RESP:
  - resp_valid[g]=1 for one cycle. There is no backpressure; requesters must accept.
  - resp_error holds the outcome.
  - Return to IDLE; a new grant is possible in the following cycle.
- Latency: legal request accept to resp_valid = 5 + WAIT_CYCLES cycles.
- Requesters not granted keep req_valid asserted; req_ready stays 0 outside IDLE.
- write and read are never asserted in the same cycle; at most one is high in any cycle.
- Reset mid-transaction abandons it with no response. The processor's CTRL SFR keeps whatever was last written.
- req_* changes after accept have no effect because fields are latched.

Optional Feature:
- Macro: SHAPE_PROCESSOR_ARBITER_LEGALITY_CHECK_EN.
- Defined: illegal SHAPE, illegal OPERATION or illegal combination → IDLE goes directly to RESP with resp_error=1, resp_data=0 (latency 1). write and read are never asserted for that request.
- Undefined: all requests go to WRITE; illegality is reported only via the processor's error flag in ERRCHK.

Test Plan:
- Reset, then req0 RECTANGLE/AREA, WAIT_CYCLES=2 → write=1 with write_data=32'h0001_0001; read 4 cycles after write (ERRCHK + 2 WAIT + READ); resp_valid[0] 7 cycles after accept; resp_data equals the read_data value; resp_error=0.
- req0 and req1 held continuously valid → grants alternate 0,1,0,1; each transaction is completed before the next req_ready.
- With macro defined, req1 RECTANGLE/IS_EQUILATERAL → resp_valid[1] 1 cycle after accept, resp_error=1; write never asserted.
- Without macro, same request with the processor raising error → ERRCHK goes to RESP, resp_error=1, read never asserted.
- rst_n low during WAIT → all outputs 0 immediately; after release, req1 alone is granted; no stale response.
- TRIANGLE/IS_ISOSCELES with shape changed after accept → write_data=32'h0002_0011 built from the latched values.
